// File: rtl/note_scheduler.sv
// note_scheduler: queues notes and sequences them onto a wavetable address counter.
// Ports:
//    clk_i, rst_ni               clock, asynchronous active-low reset
//    note_valid_i/note_ready_o   note offer handshake (period, mode, len)
//    sample_tick_i               one-cycle strobe at the sample rate
//    stop_i                      abort current note and flush the queue
//    max_count_o, *_en_o         period and octave selects for the address counter
//    counter_clk_en_o            address counter advance strobe
//    playing_o, note_done_o      status: in PLAY, note-complete pulse
//    fifo_count_o                occupied queue entries
module note_scheduler #(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_TICKS  = 16,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          note_valid_i,
   output logic          note_ready_o,
   input  logic [9:0]    note_period_i,
   input  logic [1:0]    note_mode_i,
   input  logic [15:0]   note_len_i,
   input  logic          sample_tick_i,
   input  logic          stop_i,
   output logic [9:0]    max_count_o,
   output logic          treb_en_o,
   output logic          bass_en_o,
   output logic          doublebass_en_o,
   output logic          counter_clk_en_o,
   output logic          playing_o,
   output logic          note_done_o,
   output logic [CW-1:0] fifo_count_o
);
   typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
   state_t        state_q, state_d;
   logic [27:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q, count_d;
   logic [9:0]    max_count_q, max_count_d;
   logic [2:0]    en_q, en_d;
   logic [15:0]   rem_q, rem_d, gap_q, gap_d;
   logic          push, pop, last_gap;
   logic [9:0]    head_period;
   logic [1:0]    head_mode;
   logic [15:0]   head_len;
   assign {head_period, head_mode, head_len} = mem_q[rd_q];
   assign note_ready_o = count_q < CW'(FIFO_DEPTH);
   // stop wins over everything: no push, no pop, no completion
   assign push = note_valid_i && note_ready_o && !stop_i;
   assign pop = state_q == LOAD && !stop_i;
   assign last_gap = sample_tick_i && gap_q == 16'(GAP_TICKS - 1);
   assign playing_o = state_q == PLAY;
   // en_q is {doublebass, bass, treble}; only visible while playing
   assign {doublebass_en_o, bass_en_o, treb_en_o} = playing_o ? en_q : 3'b000;
   assign counter_clk_en_o = playing_o && sample_tick_i && !stop_i;
   assign max_count_o = max_count_q;
   assign fifo_count_o = count_q;
   always_comb begin
      state_d = state_q;
      count_d = count_q + CW'(push) - CW'(pop);
      max_count_d = max_count_q;
      en_d = en_q;
      rem_d = rem_q;
      gap_d = '0;
      note_done_o = 1'b0;
      if (stop_i) begin
         state_d = IDLE;
         count_d = '0;
      end else begin
         case (state_q)
            IDLE: state_d = |count_q ? LOAD : IDLE;
            LOAD: begin
               max_count_d = head_period;
               en_d = {head_mode == 2'b11, head_mode == 2'b10, head_mode == 2'b01};
               rem_d = head_len;
               state_d = |head_len ? PLAY : GAP;
               note_done_o = ~|head_len;
            end
            PLAY: if (sample_tick_i) begin
               // remaining saturates at 1; the final tick ends the note
               rem_d = rem_q > 16'd1 ? rem_q - 16'd1 : rem_q;
               state_d = rem_q > 16'd1 ? PLAY : GAP;
               note_done_o = rem_q <= 16'd1;
            end
            GAP: begin
               gap_d = last_gap ? '0 : gap_q + 16'(sample_tick_i);
               state_d = !last_gap ? GAP : |count_q ? LOAD : IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         count_q <= '0;
         wr_q <= '0;
         rd_q <= '0;
         max_count_q <= '0;
         en_q <= '0;
         rem_q <= '0;
         gap_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wr_q <= stop_i ? '0 : wr_q + AW'(push);
         rd_q <= stop_i ? '0 : rd_q + AW'(pop);
         max_count_q <= max_count_d;
         en_q <= en_d;
         rem_q <= rem_d;
         gap_q <= gap_d;
      end
   end
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q] <= {note_period_i, note_mode_i, note_len_i};
   end
endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed vectors and corner-case sequences for note_scheduler.
module tb_note_scheduler;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        note_valid = 1'b0, sample_tick = 1'b0, stop = 1'b0;
   logic [9:0]  note_period = '0;
   logic [1:0]  note_mode = '0;
   logic [15:0] note_len = '0;
   logic        note_ready, treb_en, bass_en, doublebass_en, counter_clk_en, playing, note_done;
   logic [9:0]  max_count;
   logic [2:0]  fifo_count;
   logic [2:0]  en;
   int          n_chk = 0, n_fail = 0, done_cnt = 0;
   logic        prev_play = 1'b0;
   logic [9:0]  plog [$];

   assign en = {doublebass_en, bass_en, treb_en};

   note_scheduler dut (
      .clk_i(clk), .rst_ni(rst_n),
      .note_valid_i(note_valid), .note_ready_o(note_ready),
      .note_period_i(note_period), .note_mode_i(note_mode), .note_len_i(note_len),
      .sample_tick_i(sample_tick), .stop_i(stop),
      .max_count_o(max_count), .treb_en_o(treb_en), .bass_en_o(bass_en),
      .doublebass_en_o(doublebass_en), .counter_clk_en_o(counter_clk_en),
      .playing_o(playing), .note_done_o(note_done), .fifo_count_o(fifo_count)
   );

   initial forever #5 clk = ~clk;

   always @(negedge clk) begin
      if (playing && !prev_play) plog.push_back(max_count);
      prev_play <= playing;
      if (note_done) done_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic v; logic [9:0] per; logic [1:0] mode; logic [15:0] len; logic tick; logic stp;
      logic rdy; logic play; logic done; logic cen; logic [2:0] en; logic [9:0] mc; logic [2:0] cnt;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", n, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_dut();
      rst_n = 1'b0;
      {note_valid, sample_tick, stop} = 3'b000;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      plog.delete();
      done_cnt = 0;
   endtask

   task automatic push(input logic [9:0] p, input logic [1:0] m, input logic [15:0] l);
      note_period = p;
      note_mode = m;
      note_len = l;
      note_valid = 1'b1;
      step();
      note_valid = 1'b0;
   endtask

   initial begin
      int cen_n, done_at, ticks, bad, gt, done2, k;
      bit after1, seen2, acc;
      //            v  per mode len tk stp | rdy play done cen en     mc  cnt
      tbl[0]  = '{0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 3'b000, 0,  0};
      tbl[1]  = '{1, 99,  1, 3, 0, 0,  1, 0, 0, 0, 3'b000, 0,  0};
      tbl[2]  = '{0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 3'b000, 0,  1};
      tbl[3]  = '{0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 3'b000, 0,  1};
      tbl[4]  = '{0, 0,   0, 0, 0, 0,  1, 1, 0, 0, 3'b001, 99, 0};
      tbl[5]  = '{0, 0,   0, 0, 1, 0,  1, 1, 0, 1, 3'b001, 99, 0};
      tbl[6]  = '{0, 0,   0, 0, 1, 0,  1, 1, 0, 1, 3'b001, 99, 0};
      tbl[7]  = '{0, 0,   0, 0, 1, 0,  1, 1, 1, 1, 3'b001, 99, 0};
      tbl[8]  = '{0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 3'b000, 99, 0};
      tbl[9]  = '{1, 200, 2, 0, 1, 0,  1, 0, 0, 0, 3'b000, 99, 0};
      tbl[10] = '{1, 201, 3, 4, 1, 1,  1, 0, 0, 0, 3'b000, 99, 1};
      tbl[11] = '{0, 0,   0, 0, 1, 0,  1, 0, 0, 0, 3'b000, 99, 0};

      rst_dut();
      foreach (tbl[i]) begin
         note_valid = tbl[i].v; note_period = tbl[i].per; note_mode = tbl[i].mode;
         note_len = tbl[i].len; sample_tick = tbl[i].tick; stop = tbl[i].stp;
         #2;
         chk($sformatf("v%0d_ready", i), note_ready, tbl[i].rdy);
         chk($sformatf("v%0d_playing", i), playing, tbl[i].play);
         chk($sformatf("v%0d_done", i), note_done, tbl[i].done);
         chk($sformatf("v%0d_cnt_en", i), counter_clk_en, tbl[i].cen);
         chk($sformatf("v%0d_en", i), en, tbl[i].en);
         chk($sformatf("v%0d_max_count", i), max_count, tbl[i].mc);
         chk($sformatf("v%0d_fifo_count", i), fifo_count, tbl[i].cnt);
         step();
      end
      {note_valid, sample_tick, stop} = 3'b000;

      // treble note of 3 ticks, tick every 4 clocks, full gap, back to idle
      rst_dut();
      push(99, 2'b01, 3);
      cen_n = 0; done_at = -1; ticks = 0; bad = 0;
      for (int i = 0; i < 100 && done_at < 0; i++) begin
         sample_tick = (i % 4 == 3);
         #2;
         if (sample_tick) ticks++;
         if (counter_clk_en) cen_n++;
         if (playing && (max_count != 10'd99 || en != 3'b001)) bad++;
         if (note_done) done_at = ticks;
         step();
      end
      chk("a_cnt_en_pulses", cen_n, 3);
      chk("a_done_on_tick", done_at, 3);
      chk("a_play_outputs", bad, 0);
      bad = 0;
      for (int g = 0; g < 64; g++) begin
         sample_tick = (g % 4 == 3);
         #2;
         if (playing || counter_clk_en || en != 3'b000) bad++;
         step();
      end
      sample_tick = 1'b0;
      chk("a_gap_silent", bad, 0);
      push(5, 2'b00, 2);
      step();
      step();
      chk("a_idle_replay", playing, 1);
      chk("a_mode00_en", en, 3'b000);
      chk("a_mc5", max_count, 5);

      // doublebass then bass, gap between them
      rst_dut();
      push(300, 2'b11, 2);
      push(301, 2'b10, 2);
      gt = 0; bad = 0; done2 = 0; after1 = 0; seen2 = 0;
      for (int i = 0; i < 400 && done2 < 2; i++) begin
         sample_tick = (i % 4 == 3);
         #2;
         if (playing && max_count == 10'd300 && en != 3'b100) bad++;
         if (playing && max_count == 10'd301 && en != 3'b010) bad++;
         if (!playing && (en != 3'b000 || counter_clk_en)) bad++;
         if (after1 && !playing && sample_tick && !seen2) gt++;
         if (after1 && playing) seen2 = 1;
         if (note_done) begin done2++; after1 = 1; end
         step();
      end
      sample_tick = 1'b0;
      chk("b_enables", bad, 0);
      chk("b_gap_ticks", gt, 16);
      chk("b_notes_played", plog.size(), 2);
      if (plog.size() >= 2) begin
         chk("b_first_note", plog[0], 300);
         chk("b_second_note", plog[1], 301);
      end

      // fill the queue while busy, then drain in order
      rst_dut();
      push(10, 2'b01, 1);
      step();
      step();
      k = 11;
      note_period = 10'(k); note_mode = 2'b01; note_len = 1; note_valid = 1'b1;
      for (int i = 0; i < 3000 && plog.size() < 6; i++) begin
         sample_tick = (i >= 8);
         #2;
         if (i == 6) begin
            chk("c_ready_full", note_ready, 0);
            chk("c_count_full", fifo_count, 4);
         end
         acc = note_valid && note_ready;
         step();
         if (acc) begin
            k++;
            if (k > 15) note_valid = 1'b0;
            else note_period = 10'(k);
         end
      end
      {note_valid, sample_tick} = 2'b00;
      chk("c_notes_played", plog.size(), 6);
      for (int j = 0; j < plog.size() && j < 6; j++) chk($sformatf("c_order%0d", j), plog[j], 10 + j);

      // zero-length note skips PLAY
      rst_dut();
      push(7, 2'b01, 0);
      step();
      chk("d_load_done", note_done, 1);
      chk("d_load_playing", playing, 0);
      step();
      chk("d_gap_mc", max_count, 7);
      chk("d_gap_playing", playing, 0);
      chk("d_fifo_empty", fifo_count, 0);
      for (int g = 0; g < 32; g++) begin
         sample_tick = g[0];
         step();
      end
      sample_tick = 1'b0;
      step();
      chk("d_never_played", plog.size(), 0);
      chk("d_done_count", done_cnt, 1);

      // stop during the final tick of a note with two queued
      rst_dut();
      push(50, 2'b10, 1);
      step();
      step();
      push(51, 2'b01, 3);
      push(52, 2'b01, 3);
      chk("e_queued", fifo_count, 2);
      chk("e_playing", playing, 1);
      note_period = 53; note_valid = 1'b1; sample_tick = 1'b1; stop = 1'b1;
      #2;
      chk("e_done_suppressed", note_done, 0);
      step();
      {note_valid, sample_tick, stop} = 3'b000;
      #1;
      chk("e_flushed", fifo_count, 0);
      chk("e_not_playing", playing, 0);
      chk("e_en_off", en, 3'b000);
      repeat (3) step();
      chk("e_stays_idle", playing, 0);
      chk("e_no_done", done_cnt, 0);

      // asynchronous reset in GAP, then push on the first edge
      rst_dut();
      push(77, 2'b01, 1);
      step();
      step();
      push(78, 2'b01, 1);
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("f_max_count", max_count, 0);
      chk("f_fifo_count", fifo_count, 0);
      chk("f_playing", playing, 0);
      chk("f_outputs", {en, counter_clk_en, note_done}, 0);
      #2 rst_n = 1'b1;
      note_period = 90; note_valid = 1'b1;
      step();
      note_valid = 1'b0;
      chk("f_first_push", fifo_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
